// File: rtl/sprite_arb_pkg.sv
// Shared types and defaults for the sprite ROM fetch arbiter.
// The tag index width covers the four sprite layers feeding Color_Mapper.
package sprite_arb_pkg;

    localparam int N_REQ_DEF   = 4;
    localparam int ADDR_W_DEF  = 19;
    localparam int DATA_W_DEF  = 24;
    localparam int ROM_LAT_DEF = 2;
    localparam int IDX_W       = 2;

    typedef enum logic [IDX_W-1:0] {
        REQ_END   = 2'd0,
        REQ_PEA   = 2'd1,
        REQ_ZOM   = 2'd2,
        REQ_PLANT = 2'd3
    } req_idx_e;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] index;
    } tag_t;

endpackage

// File: rtl/sprite_fetch_arbiter_rr_arbiter.sv
// Combinational one-hot arbiter: round-robin from last_gnt+1 by default,
// lowest-index fixed priority when SPRITE_ARB_FIXED_PRIO_EN is defined.
module rr_arbiter
    import sprite_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last_gnt,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_any
);

    logic [IDX_W-1:0] cand;

`ifdef SPRITE_ARB_FIXED_PRIO_EN
    logic unused_last_gnt;
    assign unused_last_gnt = ^last_gnt;
`endif

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        cand    = '0;
        for (int k = 0; k < N_REQ; k++) begin
`ifdef SPRITE_ARB_FIXED_PRIO_EN
            cand = IDX_W'(k);
`else
            cand = IDX_W'((int'(last_gnt) + 1 + k) % N_REQ);
`endif
            // First requesting candidate in search order wins; empty slots are skipped.
            if (!gnt_any && req[cand]) begin
                gnt_any   = 1'b1;
                gnt[cand] = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/sprite_fetch_arbiter.sv
// Shares the sprite ROM read port among the layer fetchers, one read per clock.
// Define SPRITE_ARB_FIXED_PRIO_EN for fixed priority (END > pea > zombie > plant).
module sprite_fetch_arbiter
    import sprite_arb_pkg::*;
#(
    parameter int N_REQ   = N_REQ_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ROM_LAT = ROM_LAT_DEF
) (
    input  logic                    CLK,
    input  logic                    Reset_n,
    input  logic                    blank,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*ADDR_W-1:0] addr,
    output logic [N_REQ-1:0]        gnt,
    output logic                    rom_rd,
    output logic [ADDR_W-1:0]       rom_addr,
    input  logic [DATA_W-1:0]       rom_data,
    output logic [N_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]       rsp_data
);

    logic [N_REQ-1:0] req_eff;
    logic [IDX_W-1:0] last_gnt;
    logic [IDX_W-1:0] gnt_idx;
    logic             gnt_any;
    tag_t             tag_p [ROM_LAT];

    assign req_eff = blank ? req : '0;

    rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_arb (
        .req      (req_eff),
        .last_gnt (last_gnt),
        .gnt      (gnt),
        .gnt_idx  (gnt_idx),
        .gnt_any  (gnt_any)
    );

    // Stage p0: grant edge registers the ROM request and launches its tag.
    // Tag stages then track the ROM latency so the response lands on the issuer.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            last_gnt  <= IDX_W'(N_REQ - 1);
            rom_rd    <= 1'b0;
            rom_addr  <= '0;
            for (int k = 0; k < ROM_LAT; k++) tag_p[k] <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
        end else begin
            rom_rd <= gnt_any;
            if (gnt_any) begin
                last_gnt <= gnt_idx;
                rom_addr <= addr[gnt_idx*ADDR_W +: ADDR_W];
            end
            tag_p[0] <= '{valid: gnt_any, index: gnt_idx};
            for (int k = 1; k < ROM_LAT; k++) tag_p[k] <= tag_p[k-1];

            rsp_valid <= '0;
            if (tag_p[ROM_LAT-1].valid) begin
                rsp_valid[tag_p[ROM_LAT-1].index] <= 1'b1;
                rsp_data                          <= rom_data;
            end
        end
    end

endmodule

// File: tb/tb_sprite_fetch_arbiter.sv
// Randomized self-checking bench for sprite_fetch_arbiter against a
// scoreboard model of round-robin grants and in-order delayed responses.
module tb_sprite_fetch_arbiter;

    localparam int N       = 4;
    localparam int AW      = 19;
    localparam int DW      = 24;
    localparam int LAT     = 2;

    logic              CLK = 1'b0;
    logic              Reset_n;
    logic              blank;
    logic [N-1:0]      req;
    logic [N*AW-1:0]   addr;
    logic [N-1:0]      gnt;
    logic              rom_rd;
    logic [AW-1:0]     rom_addr;
    logic [DW-1:0]     rom_data;
    logic [N-1:0]      rsp_valid;
    logic [DW-1:0]     rsp_data;

    sprite_fetch_arbiter #(
        .N_REQ   (N),
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .ROM_LAT (LAT)
    ) dut (
        .CLK       (CLK),
        .Reset_n   (Reset_n),
        .blank     (blank),
        .req       (req),
        .addr      (addr),
        .gnt       (gnt),
        .rom_rd    (rom_rd),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data)
    );

    always #10 CLK = ~CLK;

    function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
        return {a[18:11] ^ 8'h39, a[10:0] ^ 11'h0A5, a[4:0]};
    endfunction

    // Synchronous ROM: address sampled on the edge after rom_addr appears.
    always @(posedge CLK) rom_data <= rom_word(rom_addr);

    typedef struct {
        int          idx;
        logic [AW-1:0] a;
        int          due;
    } pend_t;

    pend_t         pend [$];
    logic [AW-1:0] addr_tab [N];
    int            last_g;
    int            last_pick;
    int            cyc;
    logic          exp_rd;
    logic [AW-1:0] exp_addr;
    int            n_tests;
    int            n_fail;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int model_pick(input logic [N-1:0] r, input logic b, input int last);
        if (!b || r == '0) return -1;
`ifdef SPRITE_ARB_FIXED_PRIO_EN
        for (int k = 0; k < N; k++) if (r[k]) return k;
`else
        for (int k = 1; k <= N; k++) if (r[(last + k) % N]) return (last + k) % N;
`endif
        return -1;
    endfunction

    task automatic check_outputs();
        logic [N-1:0]  ev;
        logic [DW-1:0] ed;
        ev = '0;
        ed = '0;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            ev = N'(1) << pend[0].idx;
            ed = rom_word(pend[0].a);
            void'(pend.pop_front());
        end
        check("rsp_valid", 32'(rsp_valid), 32'(ev));
        if (ev != '0) check("rsp_data", 32'(rsp_data), 32'(ed));
        check("rom_rd", 32'(rom_rd), 32'(exp_rd));
        if (exp_rd) check("rom_addr", 32'(rom_addr), 32'(exp_addr));
    endtask

    task automatic tick(input logic [N-1:0] r, input logic b);
        logic [N-1:0] eg;
        @(negedge CLK);
        check_outputs();
        req   = r;
        blank = b;
        for (int i = 0; i < N; i++) addr[i*AW +: AW] = addr_tab[i];
        #1;
        last_pick = model_pick(r, b, last_g);
        eg = (last_pick >= 0) ? (N'(1) << last_pick) : '0;
        check("gnt", 32'(gnt), 32'(eg));
        if (last_pick >= 0) begin
            last_g   = last_pick;
            exp_rd   = 1'b1;
            exp_addr = addr_tab[last_pick];
            pend.push_back('{idx: last_pick, a: addr_tab[last_pick], due: cyc + 1 + LAT});
        end else begin
            exp_rd = 1'b0;
        end
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        Reset_n = 1'b0;
        req     = '0;
        blank   = 1'b0;
        #1;
        check("rst_rom_rd", 32'(rom_rd), 32'(0));
        check("rst_rom_addr", 32'(rom_addr), 32'(0));
        check("rst_rsp_valid", 32'(rsp_valid), 32'(0));
        check("rst_rsp_data", 32'(rsp_data), 32'(0));
        @(negedge CLK);
        Reset_n  = 1'b1;
        pend.delete();
        last_g   = N - 1;
        exp_rd   = 1'b0;
        exp_addr = '0;
        cyc     += 2;
    endtask

    initial begin
        logic [N-1:0] held;
        n_tests  = 0;
        n_fail   = 0;
        cyc      = 0;
        last_g   = N - 1;
        exp_rd   = 1'b0;
        exp_addr = '0;
        Reset_n  = 1'b0;
        blank    = 1'b0;
        req      = '0;
        addr     = '0;
        for (int i = 0; i < N; i++) addr_tab[i] = '0;
        #5;
        do_reset();

        // Single request from plant layer
        addr_tab[3] = 19'h01234;
        tick(4'b1000, 1'b1);
        check("single_gnt", 32'(gnt), 32'(4'b1000));
        tick(4'b0000, 1'b1);
        check("single_rom_rd", 32'(rom_rd), 32'(1));
        check("single_rom_addr", 32'(rom_addr), 32'(19'h01234));
        tick(4'b0000, 1'b1);
        tick(4'b0000, 1'b1);
        check("single_rsp_valid", 32'(rsp_valid), 32'(4'b1000));
        check("single_rsp_data", 32'(rsp_data), 32'(rom_word(19'h01234)));

        // Wrap from index 3 back to index 0
        addr_tab[0] = 19'h00AAA;
        tick(4'b1001, 1'b1);
        check("wrap_gnt", 32'(gnt), 32'(4'b0001));
        for (int k = 0; k < 4; k++) tick(4'b0000, 1'b1);

        // All four held after reset: back-to-back rotation
        do_reset();
        for (int i = 0; i < N; i++) addr_tab[i] = 19'(32'h100 * (i + 1) + 32'h5);
        for (int k = 0; k < 8; k++) tick(4'hF, 1'b1);
        // Blank falls: no grants, the last in-flight reads still respond
        for (int k = 0; k < 5; k++) tick(4'hF, 1'b0);
        check("blank_gnt", 32'(gnt), 32'(0));

        // Reset with two reads in flight discards them and restarts rotation
        do_reset();
        tick(4'hF, 1'b1);
        tick(4'hF, 1'b1);
        do_reset();
        tick(4'b0100, 1'b1);
        check("post_rst_gnt", 32'(gnt), 32'(4'b0100));
        for (int k = 0; k < 4; k++) tick(4'b0000, 1'b1);

        // Randomized traffic with requests held until granted
        held = '0;
        for (int n = 0; n < 2000; n++) begin
            for (int i = 0; i < N; i++) begin
                if (!held[i] && $urandom_range(0, 2) == 0) begin
                    held[i]     = 1'b1;
                    addr_tab[i] = 19'($urandom);
                end
            end
            tick(held, ($urandom_range(0, 9) != 0));
            if (last_pick >= 0) begin
                held[last_pick] = ($urandom_range(0, 1) == 1);
                if (held[last_pick]) addr_tab[last_pick] = 19'($urandom);
            end
            if ($urandom_range(0, 249) == 0) begin
                do_reset();
                held = '0;
            end
        end
        for (int k = 0; k < 5; k++) tick(4'b0000, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
